tx_scheduler: RTL and testbench

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/usb_tx_pkg.sv | 26 ++
 rtl/flex_counter.sv | 39 +++
 rtl/tx_scheduler.sv | 125 ++++++++++++
 tb/tb_tx_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared USB transmit definitions: scheduler states and the packet codes
// exchanged between the scheduler and the encoder.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_EOP = 2'd2,
    GAP      = 2'd3
  } tx_state_t;

  typedef logic [2:0] pid_t;

  localparam pid_t PID_NONE  = 3'd0;
  localparam pid_t PID_DATA0 = 3'd1;
  localparam pid_t PID_ACK   = 3'd2;
  localparam pid_t PID_NAK   = 3'd3;
  localparam pid_t PID_STALL = 3'd4;

  localparam int CNT_W = 10;

  function automatic logic is_handshake(input pid_t code);
    return (code == PID_ACK) || (code == PID_NAK) || (code == PID_STALL);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Enable-gated cycle counter; rollover_flag marks the enabled cycle that
// completes rollover_val counts, after which the count restarts from zero.
module flex_counter
  import usb_tx_pkg::*;
#(
  parameter int NUM_CNT_BITS = CNT_W
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count;
  logic [NUM_CNT_BITS-1:0] count_next;

  assign rollover_flag = count_enable && !clear &&
                         (count == rollover_val - NUM_CNT_BITS'(1));

  always_comb begin
    count_next = count;
    if (clear || rollover_flag) begin
      count_next = '0;
    end else if (count_enable) begin
      count_next = count + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk, negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// Arbitrates handshake and DATA0 transmit requests onto the encoder, with an
// EOP timeout and a fixed inter-packet gap after every packet.
module tx_scheduler
  import usb_tx_pkg::*;
#(
  parameter int IPG_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic [2:0] hs_type,
  input  logic       data_req,
  input  logic [6:0] buffer_occupancy,
  input  logic       end_packet,
  output logic       begin_packet,
  output logic [2:0] tx_packet,
  output logic       hs_done,
  output logic       data_done,
  output logic       tx_error,
  output logic       busy
);

  tx_state_t state;
  tx_state_t state_next;
  pid_t      code;
  pid_t      code_next;
  logic      hs_done_next;
  logic      data_done_next;
  logic      error_next;
  logic      gap_hit;
  logic      timeout_hit;

  // Occupancy never gates a grant: an empty FIFO still yields a zero-length DATA0.
  logic unused_occupancy;
  assign unused_occupancy = ^buffer_occupancy;

  flex_counter #(.NUM_CNT_BITS(CNT_W)) timeout_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state != WAIT_EOP),
    .count_enable (state == WAIT_EOP),
    .rollover_val (CNT_W'(TIMEOUT_CYCLES)),
    .rollover_flag(timeout_hit)
  );

  flex_counter #(.NUM_CNT_BITS(CNT_W)) gap_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state != GAP),
    .count_enable (state == GAP),
    .rollover_val (CNT_W'(IPG_CYCLES)),
    .rollover_flag(gap_hit)
  );

  always_ff @(posedge clk, negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      code      <= PID_NONE;
      hs_done   <= 1'b0;
      data_done <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      state     <= state_next;
      code      <= code_next;
      hs_done   <= hs_done_next;
      data_done <= data_done_next;
      tx_error  <= error_next;
    end
  end

  always_comb begin
    state_next     = state;
    code_next      = code;
    hs_done_next   = 1'b0;
    data_done_next = 1'b0;
    error_next     = 1'b0;
    begin_packet   = 1'b0;
    tx_packet      = PID_NONE;
    busy           = (state != IDLE);

    case (state)
      IDLE: begin
        // A handshake whose done pulse is still showing is the one just
        // rejected; its requester has not yet had a chance to drop it.
        if (hs_req && !hs_done) begin
          if (is_handshake(hs_type)) begin
            code_next  = hs_type;
            state_next = GRANT;
          end else begin
            error_next   = 1'b1;
            hs_done_next = 1'b1;
          end
        end else if (data_req) begin
          code_next  = PID_DATA0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        begin_packet = 1'b1;
        tx_packet    = code;
        state_next   = WAIT_EOP;
      end
      WAIT_EOP: begin
        tx_packet = code;
        if (end_packet || timeout_hit) begin
          state_next = GAP;
          error_next = !end_packet;
          if (code == PID_DATA0) begin
            data_done_next = 1'b1;
          end else begin
            hs_done_next = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: a timestamp-based model of grants, completions and
// gaps is compared against every output on every cycle, plus literal pins.
module tb_tx_scheduler;

  localparam int IPG = 8;
  localparam int TMO = 1023;
  localparam int BIG = 1 << 30;

  logic       clk;
  logic       n_rst;
  logic       hs_req;
  logic [2:0] hs_type;
  logic       data_req;
  logic [6:0] buffer_occupancy;
  logic       end_packet;
  logic       begin_packet;
  logic [2:0] tx_packet;
  logic       hs_done;
  logic       data_done;
  logic       tx_error;
  logic       busy;

  tx_scheduler #(.IPG_CYCLES(IPG), .TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .hs_req          (hs_req),
    .hs_type         (hs_type),
    .data_req        (data_req),
    .buffer_occupancy(buffer_occupancy),
    .end_packet      (end_packet),
    .begin_packet    (begin_packet),
    .tx_packet       (tx_packet),
    .hs_done         (hs_done),
    .data_done       (data_done),
    .tx_error        (tx_error),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: cycle index and the cycles at which each event of the current
  // packet happens (grant, completion pulse, first idle cycle after the gap).
  int       t = 0;
  int       g_cyc = -10;
  int       d_cyc = -10;
  int       f_cyc = -10;
  int       inv_cyc = -10;
  logic [2:0] m_code = 3'd0;
  bit       d_err = 1'b0;

  logic       s_begin, s_busy, s_hs, s_dd, s_err;
  logic [2:0] s_tx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, t);
    end
  endtask

  task automatic compare_cycle();
    logic       e_begin, e_busy, e_hs, e_dd, e_err;
    logic [2:0] e_tx;
    if (!n_rst) begin
      e_begin = 0; e_busy = 0; e_hs = 0; e_dd = 0; e_err = 0; e_tx = 3'd0;
    end else begin
      e_begin = (t == g_cyc);
      e_tx    = (t >= g_cyc && t < d_cyc) ? m_code : 3'd0;
      e_busy  = (t >= g_cyc && t < f_cyc);
      e_hs    = (t == d_cyc && m_code != 3'd1) || (t == inv_cyc);
      e_dd    = (t == d_cyc && m_code == 3'd1);
      e_err   = (t == d_cyc && d_err) || (t == inv_cyc);
    end
    chk("cyc_begin_packet", 32'(begin_packet), 32'(e_begin));
    chk("cyc_tx_packet",    32'(tx_packet),    32'(e_tx));
    chk("cyc_busy",         32'(busy),         32'(e_busy));
    chk("cyc_hs_done",      32'(hs_done),      32'(e_hs));
    chk("cyc_data_done",    32'(data_done),    32'(e_dd));
    chk("cyc_tx_error",     32'(tx_error),     32'(e_err));
  endtask

  // Inputs seen at the edge closing cycle t decide what happens from t+1 on.
  task automatic model_edge();
    bit idle, waiting;
    if (!n_rst) begin
      g_cyc = -10; d_cyc = -10; f_cyc = -10; inv_cyc = -10;
      m_code = 3'd0; d_err = 1'b0;
      return;
    end
    idle    = (t >= f_cyc);
    waiting = (d_cyc == BIG) && (t > g_cyc);
    if (idle) begin
      if (hs_req && t != inv_cyc) begin
        if (hs_type >= 3'd2 && hs_type <= 3'd4) begin
          g_cyc = t + 1; d_cyc = BIG; f_cyc = BIG; m_code = hs_type;
        end else begin
          inv_cyc = t + 1;
        end
      end else if (data_req) begin
        g_cyc = t + 1; d_cyc = BIG; f_cyc = BIG; m_code = 3'd1;
      end
    end else if (waiting) begin
      if (end_packet) begin
        d_cyc = t + 1; f_cyc = t + 1 + IPG; d_err = 1'b0;
      end else if (t - g_cyc == TMO) begin
        d_cyc = t + 1; f_cyc = t + 1 + IPG; d_err = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_begin = begin_packet; s_tx = tx_packet; s_busy = busy;
    s_hs = hs_done; s_dd = data_done; s_err = tx_error;
    compare_cycle();
    @(posedge clk);
    model_edge();
    t++;
    #1;
  endtask

  initial begin
    bit saw_done;
    int r;
    n_rst = 1'b0; hs_req = 1'b0; hs_type = 3'd0; data_req = 1'b0;
    end_packet = 1'b0; buffer_occupancy = 7'd0;

    repeat (3) step();
    chk("reset_busy", 32'(s_busy), 0);
    chk("reset_tx_packet", 32'(s_tx), 0);
    n_rst = 1'b1;
    repeat (2) step();

    // stray end_packet while idle
    end_packet = 1'b1; step(); end_packet = 1'b0; step();
    chk("stray_eop_busy", 32'(s_busy), 0);
    chk("stray_eop_pulses", 32'({s_hs, s_dd, s_err, s_begin}), 0);

    // ACK, end_packet 20 cycles after the grant
    hs_req = 1'b1; hs_type = 3'd2; step(); step();
    chk("ack_begin", 32'(s_begin), 1);
    chk("ack_tx_packet", 32'(s_tx), 2);
    repeat (19) step();
    end_packet = 1'b1; step(); end_packet = 1'b0; step();
    chk("ack_hs_done", 32'(s_hs), 1);
    chk("ack_no_error", 32'(s_err), 0);
    hs_req = 1'b0;
    repeat (7) step();
    chk("ack_gap_busy", 32'(s_busy), 1);
    step();
    chk("ack_idle_after_gap", 32'(s_busy), 0);

    // handshake and data together: handshake first, data after the gap
    hs_req = 1'b1; hs_type = 3'd2; data_req = 1'b1; buffer_occupancy = 7'd40;
    step(); step();
    chk("both_first_tx", 32'(s_tx), 2);
    repeat (4) step();
    end_packet = 1'b1; step(); end_packet = 1'b0; step();
    chk("both_hs_done", 32'(s_hs), 1);
    chk("both_no_data_done", 32'(s_dd), 0);
    hs_req = 1'b0;
    repeat (8) begin
      step();
      chk("both_gap_no_begin", 32'(s_begin), 0);
    end
    step();
    chk("both_data_begin", 32'(s_begin), 1);
    chk("both_data_tx", 32'(s_tx), 1);
    repeat (3) step();
    end_packet = 1'b1; step(); end_packet = 1'b0; step();
    chk("both_data_done", 32'(s_dd), 1);
    data_req = 1'b0;
    repeat (10) step();

    // zero-length DATA0 that never sees end_packet
    buffer_occupancy = 7'd0; data_req = 1'b1; step(); step();
    chk("to_begin", 32'(s_begin), 1);
    chk("to_tx_packet", 32'(s_tx), 1);
    repeat (TMO) step();
    chk("to_no_error_yet", 32'(s_err), 0);
    step();
    chk("to_error", 32'(s_err), 1);
    chk("to_data_done", 32'(s_dd), 1);
    data_req = 1'b0;
    repeat (8) step();
    chk("to_back_idle", 32'(s_busy), 0);

    // invalid handshake code
    hs_req = 1'b1; hs_type = 3'd5; step(); step();
    chk("inv_error", 32'(s_err), 1);
    chk("inv_hs_done", 32'(s_hs), 1);
    chk("inv_no_begin", 32'(s_begin), 0);
    chk("inv_not_busy", 32'(s_busy), 0);
    hs_req = 1'b0; step();
    chk("inv_no_repeat", 32'({s_err, s_hs}), 0);

    // reset in the middle of a packet
    data_req = 1'b1; step(); step(); repeat (3) step();
    n_rst = 1'b0; data_req = 1'b0; step();
    chk("midrst_busy", 32'(s_busy), 0);
    chk("midrst_tx_packet", 32'(s_tx), 0);
    step();
    n_rst = 1'b1;
    saw_done = 1'b0;
    end_packet = 1'b1; step(); end_packet = 1'b0;
    saw_done = saw_done | s_dd | s_hs | s_err;
    repeat (11) begin
      step();
      saw_done = saw_done | s_dd | s_hs | s_err;
    end
    chk("midrst_no_done", 32'(saw_done), 0);

    // randomized traffic with level requesters that drop after their done
    repeat (4000) begin
      if (!n_rst) n_rst = 1'b1;
      else if ($urandom_range(0, 599) == 0) n_rst = 1'b0;
      if (hs_req && s_hs) hs_req = 1'b0;
      else if (!hs_req && $urandom_range(0, 5) == 0) begin
        hs_req = 1'b1;
        r = int'($urandom_range(0, 9));
        hs_type = (r < 8) ? 3'(2 + r % 3) : ((r == 8) ? 3'd5 : 3'd0);
      end
      if (data_req && s_dd) data_req = 1'b0;
      else if (!data_req && $urandom_range(0, 5) == 0) data_req = 1'b1;
      end_packet = ($urandom_range(0, 9) == 0);
      buffer_occupancy = 7'($urandom_range(0, 127));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
